// File: rtl/lm_sm_sequencer_if.sv
// Decode-stage bundle between the pipeline and the LM/SM micro-op sequencer.
// master: the decode/pipeline side, drives the instruction word, hold and flush,
//         and receives the micro-op fields, stall request and done pulse.
// slave : the sequencer itself.
interface lm_sm_sequencer_if;
  logic        inst_valid;
  logic [15:0] inst_word;
  logic        hold;
  logic        flush;
  logic        lm_sm_stall;
  logic        uop_valid;
  logic        uop_is_store;
  logic [2:0]  uop_reg;
  logic [2:0]  uop_base;
  logic [2:0]  uop_offset;
  logic        uop_last;
  logic        uop_r7;
  logic        done;

  modport master (
    output inst_valid, inst_word, hold, flush,
    input  lm_sm_stall, uop_valid, uop_is_store, uop_reg, uop_base,
           uop_offset, uop_last, uop_r7, done
  );

  modport slave (
    input  inst_valid, inst_word, hold, flush,
    output lm_sm_stall, uop_valid, uop_is_store, uop_reg, uop_base,
           uop_offset, uop_last, uop_r7, done
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple micro-op sequencer for the decode stage.
// An accepted LM/SM word has its 8-bit register list latched; one register
// transfer is issued per cycle with a running word offset from the base RA.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - slave side of lm_sm_sequencer_if:
//           inst_valid/inst_word/hold/flush in,
//           lm_sm_stall, uop_* fields and done out.
module lm_sm_sequencer #(
  parameter logic [3:0] LM_OPCODE = 4'b0110,
  parameter logic [3:0] SM_OPCODE = 4'b0111,
  parameter bit         MSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  lm_sm_sequencer_if.slave   bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_next;
  logic [7:0]  mask, mask_next;
  logic [2:0]  offset, offset_next;
  logic [2:0]  base, base_next;
  logic        is_store, is_store_next;
  logic        done_q, done_next;

  logic [3:0]  opcode;
  logic [7:0]  list;
  logic        is_lmsm;
  logic        in_run;
  logic        accept;
  logic        consume;
  logic [2:0]  cur_reg;
  logic        cur_last;
  logic        unused_word_bit;

  // Register chosen for the current transfer: lowest set bit, or highest
  // when scanning from R7 down. The later loop iterations win.
  function automatic logic [2:0] pick_reg(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (MSB_FIRST) begin
        r = m[i] ? 3'(i) : r;
      end else begin
        r = m[7-i] ? 3'(7-i) : r;
      end
    end
    return r;
  endfunction

  // Exactly one bit left means the current transfer is the final one.
  function automatic logic one_left(input logic [7:0] m);
    return (m != 8'd0) && ((m & (m - 8'd1)) == 8'd0);
  endfunction

  assign unused_word_bit = bus.inst_word[8];

  // Decode of the incoming word and the handshake qualifiers.
  always_comb begin
    opcode   = bus.inst_word[15:12];
    list     = bus.inst_word[7:0];
    is_lmsm  = (opcode == LM_OPCODE) || (opcode == SM_OPCODE);
    in_run   = (state == RUN);
    accept   = !in_run && bus.inst_valid && is_lmsm && !bus.flush && !bus.hold;
    consume  = in_run && !bus.hold && !bus.flush;
    cur_reg  = pick_reg(mask);
    cur_last = one_left(mask);
  end

  // Next-state logic; flush overrides everything else.
  always_comb begin
    state_next    = state;
    mask_next     = mask;
    offset_next   = offset;
    base_next     = base;
    is_store_next = is_store;
    done_next     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (list != 8'd0)) begin
          state_next    = RUN;
          mask_next     = list;
          offset_next   = 3'd0;
          base_next     = bus.inst_word[11:9];
          is_store_next = (opcode == SM_OPCODE);
        end else if (accept) begin
          // Empty list: nothing to transfer, just report completion.
          done_next = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (consume) begin
          mask_next   = mask & ~(8'd1 << cur_reg);
          // At most 8 transfers, so the 3-bit offset never wraps mid-sequence.
          offset_next = offset + 3'd1;
          if (cur_last) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = RUN;
          end
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
        mask_next  = 8'd0;
      end
    endcase
    if (bus.flush) begin
      state_next  = IDLE;
      mask_next   = 8'd0;
      offset_next = 3'd0;
      done_next   = 1'b0;
    end else begin
      done_next = done_next;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mask     <= 8'd0;
      offset   <= 3'd0;
      base     <= 3'd0;
      is_store <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      mask     <= mask_next;
      offset   <= offset_next;
      base     <= base_next;
      is_store <= is_store_next;
      done_q   <= done_next;
    end
  end

  // Micro-op fields are forced to zero outside RUN so idle cycles read clean.
  assign bus.uop_valid    = in_run;
  assign bus.uop_is_store = in_run & is_store;
  assign bus.uop_reg      = in_run ? cur_reg : 3'd0;
  assign bus.uop_base     = in_run ? base : 3'd0;
  assign bus.uop_offset   = in_run ? offset : 3'd0;
  assign bus.uop_last     = in_run & cur_last;
  assign bus.uop_r7       = in_run & !is_store & (cur_reg == 3'd7);
  // Stall drops on the last consume cycle so the next word enters decode.
  assign bus.lm_sm_stall  = in_run ? !(cur_last & !bus.hold)
                                   : (accept & (list != 8'd0));
  assign bus.done         = done_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench: two sequencers (LSB-first and MSB-first scan) driven
// with identical stimulus and compared against a list-based reference model.
module tb_lm_sm_sequencer;

  logic clk;
  logic reset;

  lm_sm_sequencer_if ifa ();
  lm_sm_sequencer_if ifb ();

  lm_sm_sequencer #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(ifa));
  lm_sm_sequencer #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // {valid, store, reg, base, offset, last, r7, stall, done}
  logic [14:0] act [2];
  assign act[0] = {ifa.uop_valid, ifa.uop_is_store, ifa.uop_reg, ifa.uop_base,
                   ifa.uop_offset, ifa.uop_last, ifa.uop_r7, ifa.lm_sm_stall, ifa.done};
  assign act[1] = {ifb.uop_valid, ifb.uop_is_store, ifb.uop_reg, ifb.uop_base,
                   ifb.uop_offset, ifb.uop_last, ifb.uop_r7, ifb.lm_sm_stall, ifb.done};

  function automatic logic [14:0] pk(input logic v, input logic st, input logic [2:0] r,
                                     input logic [2:0] b, input logic [2:0] o,
                                     input logic l, input logic r7, input logic s,
                                     input logic d);
    return {v, st, r, b, o, l, r7, s, d};
  endfunction

  // Reference model: the ordered list of registers still to transfer.
  int   seq [2][8];
  int   n   [2];
  int   pos [2];
  int   base_m [2];
  bit   st_m [2];
  bit   done_m [2];

  function automatic bit is_acc(input int m, input logic v, input logic [15:0] w,
                                input logic h, input logic f);
    return (pos[m] >= n[m]) && v && (w[15:12] == 4'd6 || w[15:12] == 4'd7) && !f && !h;
  endfunction

  function automatic logic [14:0] model_out(input int m, input logic v, input logic [15:0] w,
                                            input logic h, input logic f);
    if (pos[m] < n[m]) begin
      int  r;
      bit  last;
      r    = seq[m][pos[m]];
      last = (pos[m] == n[m] - 1);
      return pk(1'b1, st_m[m], 3'(r), 3'(base_m[m]), 3'(pos[m]), last,
                !st_m[m] && r == 7, !(last && !h), done_m[m]);
    end
    return pk(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0,
              is_acc(m, v, w, h, f) && w[7:0] != 8'd0, done_m[m]);
  endfunction

  task automatic model_step(input logic v, input logic [15:0] w, input logic h, input logic f);
    for (int m = 0; m < 2; m++) begin
      bit acc;
      acc = is_acc(m, v, w, h, f);
      done_m[m] = 1'b0;
      if (f) begin
        n[m] = 0; pos[m] = 0;
      end else if (pos[m] < n[m] && !h) begin
        pos[m]++;
        if (pos[m] == n[m]) begin
          done_m[m] = 1'b1; n[m] = 0; pos[m] = 0;
        end
      end else if (acc) begin
        n[m] = 0; pos[m] = 0;
        for (int k = 0; k < 8; k++) begin
          int r;
          r = (m == 1) ? 7 - k : k;
          if (w[r]) begin
            seq[m][n[m]] = r;
            n[m]++;
          end
        end
        base_m[m] = int'(w[11:9]);
        st_m[m]   = (w[15:12] == 4'd7);
        if (n[m] == 0) done_m[m] = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      n[m] = 0; pos[m] = 0; done_m[m] = 1'b0; base_m[m] = 0; st_m[m] = 1'b0;
    end
  endtask

  task automatic check(input string name, input int m, input logic [14:0] got,
                       input logic [14:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d: got=%h want=%h (v st reg base off last r7 stall done)",
               name, m, got, want);
    end
  endtask

  // One clock cycle: drive, check pre-edge outputs, clock, advance model.
  task automatic cycle(input string name, input logic v, input logic [15:0] w,
                       input logic h, input logic f,
                       input bit use_tab, input logic [14:0] tab_exp);
    ifa.inst_valid = v; ifa.inst_word = w; ifa.hold = h; ifa.flush = f;
    ifb.inst_valid = v; ifb.inst_word = w; ifb.hold = h; ifb.flush = f;
    #3;
    for (int m = 0; m < 2; m++) check(name, m, act[m], model_out(m, v, w, h, f));
    if (use_tab) check({name, "_tab"}, 0, act[0], tab_exp);
    @(posedge clk);
    #1;
    model_step(v, w, h, f);
  endtask

  typedef struct {
    logic        v;
    logic [15:0] w;
    logic        h;
    logic        f;
    logic [14:0] e;
  } vec_t;

  vec_t tab [7];

  initial begin
    // LM RA=3 list=1010_0101, LSB-first expectations.
    tab[0] = '{1'b1, 16'h66A5, 1'b0, 1'b0, pk(0,0,3'd0,3'd0,3'd0,0,0,1,0)};
    tab[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, pk(1,0,3'd0,3'd3,3'd0,0,0,1,0)};
    tab[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, pk(1,0,3'd2,3'd3,3'd1,0,0,1,0)};
    tab[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, pk(1,0,3'd5,3'd3,3'd2,0,0,1,0)};
    tab[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, pk(1,0,3'd7,3'd3,3'd3,1,1,0,0)};
    tab[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, pk(0,0,3'd0,3'd0,3'd0,0,0,0,1)};
    tab[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, pk(0,0,3'd0,3'd0,3'd0,0,0,0,0)};

    reset = 1'b0;
    ifa.inst_valid = 1'b0; ifa.inst_word = 16'h0000; ifa.hold = 1'b0; ifa.flush = 1'b0;
    ifb.inst_valid = 1'b0; ifb.inst_word = 16'h0000; ifb.hold = 1'b0; ifb.flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) check("reset_state", m, act[m], 15'd0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) cycle("lm_a5", tab[i].v, tab[i].w, tab[i].h, tab[i].f, 1'b1, tab[i].e);

    // SM list=FF: full eight transfers, offsets 0..7.
    cycle("sm_ff", 1'b1, 16'h72FF, 1'b0, 1'b0, 1'b0, 15'd0);
    for (int i = 0; i < 10; i++) cycle("sm_ff", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 15'd0);

    // LM empty list: no micro-ops, done the next cycle.
    cycle("lm_empty", 1'b1, 16'h6400, 1'b0, 1'b0, 1'b0, 15'd0);
    for (int i = 0; i < 2; i++) cycle("lm_empty", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 15'd0);

    // SM list=0001_0010 with hold for 3 cycles on the first micro-op.
    cycle("sm_hold", 1'b1, 16'h7A12, 1'b0, 1'b0, 1'b0, 15'd0);
    for (int i = 0; i < 3; i++) cycle("sm_hold", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 15'd0);
    for (int i = 0; i < 4; i++) cycle("sm_hold", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 15'd0);

    // LM list=0F flushed on the second micro-op, then restarted at once.
    cycle("lm_flush", 1'b1, 16'h620F, 1'b0, 1'b0, 1'b0, 15'd0);
    cycle("lm_flush", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 15'd0);
    cycle("lm_flush", 1'b1, 16'h620F, 1'b0, 1'b1, 1'b0, 15'd0);
    cycle("lm_flush", 1'b1, 16'h620F, 1'b0, 1'b0, 1'b0, 15'd0);
    for (int i = 0; i < 6; i++) cycle("lm_flush", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 15'd0);

    // Asynchronous reset in the middle of an LM F0 sequence.
    cycle("lm_rst", 1'b1, 16'h60F0, 1'b0, 1'b0, 1'b0, 15'd0);
    cycle("lm_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 15'd0);
    reset = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) check("async_reset", m, act[m], 15'd0);
    reset = 1'b1;
    model_reset();
    cycle("after_rst", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 15'd0);
    cycle("after_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 15'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic        v, h, f;
      logic [15:0] w;
      int          sel;
      v   = ($urandom % 4) != 0;
      w   = 16'($urandom);
      sel = $urandom % 8;
      if (sel < 3) w[15:12] = 4'd6;
      else if (sel < 6) w[15:12] = 4'd7;
      else w[15:12] = w[15:12];
      if (($urandom % 8) == 0) w[7:0] = 8'd0;
      h = ($urandom % 6) == 0;
      f = ($urandom % 14) == 0;
      cycle("random", v, w, h, f, 1'b0, 15'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
